// File: rtl/controller_sequencer_if.sv
// Sequencer bus: T-state ring and opcode in, SAP-1 control word and status out.
// The signal names are those of the original controller_sequencer ports.
interface controller_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic [5:0]       t;
    logic [3:0]       opcode;
    logic [11:0]      con;
    logic             hlt;
    logic             sync_err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output t,
        output opcode,
        input  con,
        input  hlt,
        input  sync_err,
        input  instr_count
    );

    modport slave (
        input  t,
        input  opcode,
        output con,
        output hlt,
        output sync_err,
        output instr_count
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control sequencer: decodes the one-hot T-state and the opcode into CON.
// It also holds the HLT latch, a shadow-ring sync checker and a retired-instruction counter.
module controller_sequencer #(
    parameter int unsigned CNT_W  = 8,
    parameter logic [3:0]  OP_LDA = 4'h0,
    parameter logic [3:0]  OP_ADD = 4'h1,
    parameter logic [3:0]  OP_SUB = 4'h2,
    parameter logic [3:0]  OP_OUT = 4'hE,
    parameter logic [3:0]  OP_HLT = 4'hF
) (
    input  logic                  clk,
    input  logic                  res,
    controller_sequencer_if.slave bus
);

    // {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
    localparam logic [11:0] CON_IDLE  = 12'h3E3;
    localparam logic [11:0] CON_F1    = 12'h5E3;
    localparam logic [11:0] CON_F2    = 12'hBE3;
    localparam logic [11:0] CON_F3    = 12'h263;
    localparam logic [11:0] CON_MAR   = 12'h1A3;
    localparam logic [11:0] CON_LDA5  = 12'h2C3;
    localparam logic [11:0] CON_LDB5  = 12'h2E1;
    localparam logic [11:0] CON_ADD6  = 12'h3C7;
    localparam logic [11:0] CON_SUB6  = 12'h3CF;
    localparam logic [11:0] CON_OUT4  = 12'h3F2;

    localparam logic [5:0]  T1 = 6'b100000;
    localparam logic [5:0]  T4 = 6'b000100;
    localparam logic [5:0]  T6 = 6'b000001;

    typedef enum logic [2:0] {
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_NONE
    } step_t;

    logic             r_hlt;
    logic             r_sync_err;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_exp;

    logic             w_onehot;
    logic             w_match;
    step_t            w_step;
    logic [11:0]      w_con;

    assign w_onehot = $onehot(bus.t);
    assign w_match  = (bus.t == r_exp);

    always_comb begin
        w_step = ST_NONE;
        case (bus.t)
            6'b100000: w_step = ST_T1;
            6'b010000: w_step = ST_T2;
            6'b001000: w_step = ST_T3;
            6'b000100: w_step = ST_T4;
            6'b000010: w_step = ST_T5;
            6'b000001: w_step = ST_T6;
            default:   w_step = ST_NONE;
        endcase
    end

    // Decode ignores sync_err on purpose: a flagged ring still drives valid one-hot steps.
    always_comb begin
        w_con = CON_IDLE;
        if (!r_hlt) begin
            case (w_step)
                ST_T1: w_con = CON_F1;
                ST_T2: w_con = CON_F2;
                ST_T3: w_con = CON_F3;
                ST_T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                        bus.opcode == OP_SUB) begin
                        w_con = CON_MAR;
                    end else if (bus.opcode == OP_OUT) begin
                        w_con = CON_OUT4;
                    end
                end
                ST_T5: begin
                    if (bus.opcode == OP_LDA) begin
                        w_con = CON_LDA5;
                    end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        w_con = CON_LDB5;
                    end
                end
                ST_T6: begin
                    if (bus.opcode == OP_ADD) begin
                        w_con = CON_ADD6;
                    end else if (bus.opcode == OP_SUB) begin
                        w_con = CON_SUB6;
                    end
                end
                default: w_con = CON_IDLE;
            endcase
        end
    end

    // The shadow ring free-runs and is never resynced to t, so one slip keeps flagging.
    always_ff @(posedge clk) begin
        if (res) begin
            r_hlt      <= 1'b0;
            r_sync_err <= 1'b0;
            r_cnt      <= '0;
            r_exp      <= T1;
        end else if (!r_hlt) begin
            if (!w_match || !w_onehot) begin
                r_sync_err <= 1'b1;
            end
            r_exp <= {r_exp[0], r_exp[5:1]};
            if (w_match && bus.t == T6) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (bus.t == T4 && bus.opcode == OP_HLT) begin
                r_hlt <= 1'b1;
            end
        end
    end

    assign bus.con         = w_con;
    assign bus.hlt         = r_hlt;
    assign bus.sync_err    = r_sync_err;
    assign bus.instr_count = r_cnt;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: one 8-bit and one 2-bit counter instance share stimulus.
// t/opcode/res change on negedge, like the real state counter.
module tb_controller_sequencer;

    localparam logic [5:0] T1 = 6'b100000;
    localparam logic [5:0] T2 = 6'b010000;
    localparam logic [5:0] T3 = 6'b001000;
    localparam logic [5:0] T4 = 6'b000100;
    localparam logic [5:0] T5 = 6'b000010;
    localparam logic [5:0] T6 = 6'b000001;

    localparam logic [3:0] LDA = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;

    logic       clk;
    logic       r_res;
    logic [5:0] r_t;
    logic [3:0] r_op;

    int unsigned n_checks;
    int unsigned n_fail;

    controller_sequencer_if #(.CNT_W(8)) bus8 ();
    controller_sequencer_if #(.CNT_W(2)) bus2 ();

    assign bus8.t      = r_t;
    assign bus8.opcode = r_op;
    assign bus2.t      = r_t;
    assign bus2.opcode = r_op;

    controller_sequencer #(.CNT_W(8)) u_dut8 (
        .clk (clk),
        .res (r_res),
        .bus (bus8.slave)
    );

    controller_sequencer #(.CNT_W(2)) u_dut2 (
        .clk (clk),
        .res (r_res),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] tv, input logic [3:0] op, input logic rv,
                         input logic [11:0] ec, input string tag);
        @(negedge clk);
        r_t   = tv;
        r_op  = op;
        r_res = rv;
        #1;
        check_eq(tag, {20'd0, bus8.con}, {20'd0, ec});
    endtask

    task automatic do_reset();
        @(negedge clk);
        r_res = 1'b1;
        r_t   = T1;
        r_op  = LDA;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [11:0] c4, input logic [11:0] c5,
                             input logic [11:0] c6, input string tag);
        drive(T1, op, 1'b0, 12'h5E3, {tag, " T1"});
        drive(T2, op, 1'b0, 12'hBE3, {tag, " T2"});
        drive(T3, op, 1'b0, 12'h263, {tag, " T3"});
        drive(T4, op, 1'b0, c4,      {tag, " T4"});
        drive(T5, op, 1'b0, c5,      {tag, " T5"});
        drive(T6, op, 1'b0, c6,      {tag, " T6"});
        after_edge();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        r_res    = 1'b1;
        r_t      = T1;
        r_op     = LDA;

        // 1: reset state, then LDA
        do_reset();
        check_eq("rst hlt",  {31'd0, bus8.hlt}, 32'd0);
        check_eq("rst err",  {31'd0, bus8.sync_err}, 32'd0);
        check_eq("rst cnt8", {24'd0, bus8.instr_count}, 32'd0);
        check_eq("rst cnt2", {30'd0, bus2.instr_count}, 32'd0);
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "lda");
        check_eq("lda cnt", {24'd0, bus8.instr_count}, 32'd1);

        // 2: ADD then SUB
        do_reset();
        run_instr(ADD, 12'h1A3, 12'h2E1, 12'h3C7, "add");
        run_instr(SUB, 12'h1A3, 12'h2E1, 12'h3CF, "sub");
        check_eq("addsub cnt", {24'd0, bus8.instr_count}, 32'd2);
        check_eq("addsub err", {31'd0, bus8.sync_err}, 32'd0);

        // 3: OUT then HLT; halted sequencer ignores t
        do_reset();
        run_instr(OUT, 12'h3F2, 12'h3E3, 12'h3E3, "out");
        check_eq("out cnt", {24'd0, bus8.instr_count}, 32'd1);
        drive(T1, HLT, 1'b0, 12'h5E3, "hlt T1");
        drive(T2, HLT, 1'b0, 12'hBE3, "hlt T2");
        drive(T3, HLT, 1'b0, 12'h263, "hlt T3");
        drive(T4, HLT, 1'b0, 12'h3E3, "hlt T4");
        check_eq("hlt pre", {31'd0, bus8.hlt}, 32'd0);
        after_edge();
        check_eq("hlt set", {31'd0, bus8.hlt}, 32'd1);
        drive(T5, ADD, 1'b0, 12'h3E3, "halted T5");
        drive(T6, SUB, 1'b0, 12'h3E3, "halted T6");
        drive(T1, LDA, 1'b0, 12'h3E3, "halted T1");
        drive(T3, LDA, 1'b0, 12'h3E3, "halted T3");
        after_edge();
        check_eq("halted cnt", {24'd0, bus8.instr_count}, 32'd1);
        check_eq("halted err", {31'd0, bus8.sync_err}, 32'd0);
        check_eq("halted hlt", {31'd0, bus8.hlt}, 32'd1);
        do_reset();
        check_eq("hlt clr", {31'd0, bus8.hlt}, 32'd0);

        // 4: ring slip is sticky and blocks the out-of-phase T6 count
        do_reset();
        drive(T1, LDA, 1'b0, 12'h5E3, "slip T1");
        drive(T4, LDA, 1'b0, 12'h1A3, "slip T4");
        check_eq("slip pre", {31'd0, bus8.sync_err}, 32'd0);
        after_edge();
        check_eq("slip err", {31'd0, bus8.sync_err}, 32'd1);
        drive(T5, LDA, 1'b0, 12'h2C3, "slip T5");
        drive(T6, LDA, 1'b0, 12'h3E3, "slip T6");
        after_edge();
        check_eq("slip nocnt", {24'd0, bus8.instr_count}, 32'd0);
        drive(T5, LDA, 1'b0, 12'h2C3, "resync T5");
        drive(T6, LDA, 1'b0, 12'h3E3, "resync T6");
        after_edge();
        check_eq("resync cnt", {24'd0, bus8.instr_count}, 32'd1);
        check_eq("resync err", {31'd0, bus8.sync_err}, 32'd1);

        // 5: non-one-hot t
        do_reset();
        drive(6'b110000, LDA, 1'b0, 12'h3E3, "multi con");
        check_eq("multi pre", {31'd0, bus8.sync_err}, 32'd0);
        after_edge();
        check_eq("multi err", {31'd0, bus8.sync_err}, 32'd1);
        drive(6'b000000, ADD, 1'b0, 12'h3E3, "zero con");

        // 6: counter wrap on the 2-bit instance, reset mid-instruction
        do_reset();
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "w1");
        check_eq("wrap c2 1", {30'd0, bus2.instr_count}, 32'd1);
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "w2");
        check_eq("wrap c2 2", {30'd0, bus2.instr_count}, 32'd2);
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "w3");
        check_eq("wrap c2 3", {30'd0, bus2.instr_count}, 32'd3);
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "w4");
        check_eq("wrap c2 0", {30'd0, bus2.instr_count}, 32'd0);
        run_instr(LDA, 12'h1A3, 12'h2C3, 12'h3E3, "w5");
        check_eq("wrap c2 1b", {30'd0, bus2.instr_count}, 32'd1);
        check_eq("wrap c8 5", {24'd0, bus8.instr_count}, 32'd5);
        drive(T1, LDA, 1'b0, 12'h5E3, "mid T1");
        drive(T2, LDA, 1'b0, 12'hBE3, "mid T2");
        drive(T3, LDA, 1'b1, 12'h263, "mid T3 res");
        drive(T1, LDA, 1'b0, 12'h5E3, "mid T1 after");
        check_eq("mid cnt2", {30'd0, bus2.instr_count}, 32'd0);
        check_eq("mid cnt8", {24'd0, bus8.instr_count}, 32'd0);
        check_eq("mid err", {31'd0, bus8.sync_err}, 32'd0);
        drive(T2, LDA, 1'b0, 12'hBE3, "mid T2 after");
        after_edge();
        check_eq("mid err2", {31'd0, bus8.sync_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
